// File: rtl/in_write_pkg.sv
// Shared definitions for the input-side SRAM writer and its output-side twin.
// State codes are common to both so debug tooling can decode either FSM.
package in_write_pkg;

  localparam int unsigned SRAM_DATA_BITS = 64;
  localparam int unsigned SRAM_ADDR_BITS = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sram_addr_cnt.sv
// Clear / enable up-counter with a terminal-count flag, used to sequence SRAM addresses.
// Clear wins over enable.
module sram_addr_cnt
  import in_write_pkg::*;
#(
  parameter int unsigned Width     = SRAM_ADDR_BITS,
  parameter int unsigned LastCount = (1 << SRAM_ADDR_BITS) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic             tc
);

  localparam logic [Width-1:0] LastVal = Width'(LastCount);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LastVal);

endmodule

// File: rtl/in_write.sv
// Pops ADDR_FINAL words from the input FIFO and writes them to input SRAM at 0..ADDR_FINAL-1.
// Pipeline: pop -> capture (FIFO read latency 1) -> registered SRAM write, 2 cycles total.
module in_write
  import in_write_pkg::*;
#(
  parameter int unsigned ADDR_FINAL = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      len_err,
  input  logic                      fifo_empty_n,
  output logic                      fifo_read,
  input  logic [SRAM_DATA_BITS-1:0] fifo_data,
  input  logic                      fifo_last,
  output logic                      cen_insr,
  output logic                      wen_insr,
  output logic [SRAM_ADDR_BITS-1:0] addr_insr,
  output logic [SRAM_DATA_BITS-1:0] data_to_sram
);

  // One extra bit so the pop counter can reach ADDR_FINAL=1024.
  localparam int unsigned           RdBits  = SRAM_ADDR_BITS + 1;
  localparam logic [RdBits-1:0]     RdFinal = RdBits'(ADDR_FINAL);

  state_t                      state_q, state_d;
  logic [RdBits-1:0]           rd_cnt_q, rd_cnt_d;
  logic                        pop_q;
  logic                        len_err_q, len_err_d;
  logic                        cen_q, wen_q;
  logic [SRAM_ADDR_BITS-1:0]   addr_q;
  logic [SRAM_DATA_BITS-1:0]   data_q;

  logic                        start_ok;
  logic                        last_pop;
  logic                        wr_clear;
  logic                        wr_tc;
  logic [SRAM_ADDR_BITS-1:0]   wr_cnt;

  assign start_ok  = (state_q == ST_IDLE) && start;
  assign fifo_read = (state_q == ST_READ) && fifo_empty_n && (rd_cnt_q < RdFinal);
  assign last_pop  = fifo_read && (rd_cnt_q == (RdFinal - RdBits'(1)));
  assign wr_clear  = start_ok || ((state_d == ST_DONE) && (state_q != ST_DONE));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)    state_d = ST_READ;
      ST_READ:  if (last_pop) state_d = ST_DRAIN;
      // The last pop is always still in flight on DRAIN entry, so pop_q is 1 then.
      ST_DRAIN: if (!pop_q)   state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (start_ok) begin
      rd_cnt_d = '0;
    end else if (fifo_read) begin
      rd_cnt_d = rd_cnt_q + RdBits'(1);
    end
  end

  // wr_cnt indexes the word being captured, so wr_tc marks the word that must carry fifo_last.
  always_comb begin
    len_err_d = len_err_q;
    if (start_ok) begin
      len_err_d = 1'b0;
    end else if (pop_q && (fifo_last != wr_tc)) begin
      len_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      pop_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      pop_q     <= fifo_read;
      len_err_q <= len_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cen_q <= ~pop_q;
      wen_q <= ~pop_q;
      if (pop_q) begin
        addr_q <= wr_cnt;
        data_q <= fifo_data;
      end
    end
  end

  sram_addr_cnt #(
    .Width     (SRAM_ADDR_BITS),
    .LastCount (ADDR_FINAL - 1)
  ) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (wr_clear),
    .en    (pop_q),
    .count (wr_cnt),
    .tc    (wr_tc)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign len_err      = len_err_q;
  assign cen_insr     = cen_q;
  assign wen_insr     = wen_q;
  assign addr_insr    = addr_q;
  assign data_to_sram = data_q;

endmodule

// File: tb/tb_in_write.sv
// Randomized bench for in_write: a queue-based FIFO model feeds the DUT and a transfer-level
// model predicts the write sequence, timing, busy window and len_err.
module tb_in_write;
  import in_write_pkg::*;

  localparam int unsigned AF = 20;

  logic        clk = 1'b0;
  logic        reset, start, fifo_empty_n, fifo_last;
  logic [63:0] fifo_data;
  logic        busy, done, len_err, fifo_read, cen_insr, wen_insr;
  logic [9:0]  addr_insr;
  logic [63:0] data_to_sram;

  logic        start1, fifo_empty_n1, fifo_last1;
  logic [63:0] fifo_data1;
  logic        busy1, done1, len_err1, fifo_read1, cen_insr1, wen_insr1;
  logic [9:0]  addr_insr1;
  logic [63:0] data_to_sram1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [64:0] fifo_q[$];
  bit tog = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  in_write #(.ADDR_FINAL(AF)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .len_err      (len_err),
    .fifo_empty_n (fifo_empty_n),
    .fifo_read    (fifo_read),
    .fifo_data    (fifo_data),
    .fifo_last    (fifo_last),
    .cen_insr     (cen_insr),
    .wen_insr     (wen_insr),
    .addr_insr    (addr_insr),
    .data_to_sram (data_to_sram)
  );

  in_write #(.ADDR_FINAL(1)) u_one (
    .clk          (clk),
    .reset        (reset),
    .start        (start1),
    .busy         (busy1),
    .done         (done1),
    .len_err      (len_err1),
    .fifo_empty_n (fifo_empty_n1),
    .fifo_read    (fifo_read1),
    .fifo_data    (fifo_data1),
    .fifo_last    (fifo_last1),
    .cen_insr     (cen_insr1),
    .wen_insr     (wen_insr1),
    .addr_insr    (addr_insr1),
    .data_to_sram (data_to_sram1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // FIFO model: a popped word appears on fifo_data one cycle after the pop.
  // mode 0: always ready, 1: ready every other cycle, 2: random 30% bubbles.
  task automatic drive_fifo(input int mode, input bit popped);
    bit gate;
    if (popped) begin
      {fifo_last, fifo_data} = fifo_q.pop_front();
    end else begin
      fifo_data = {$urandom, $urandom};
      fifo_last = 1'($urandom_range(1));
    end
    tog = ~tog;
    case (mode)
      0:       gate = 1'b1;
      1:       gate = tog;
      default: gate = ($urandom_range(99) >= 30);
    endcase
    fifo_empty_n = (fifo_q.size() != 0) && gate;
  endtask

  // Entered and left at #1 after a rising edge. last_pos is the word index carrying fifo_last.
  task automatic run_xfer(input int mode, input int last_pos, input bit seq_data,
                          input int reset_after, input bit hold);
    logic [63:0] words[$];
    int  pop_cyc[$];
    int  pops = 0;
    int  writes = 0;
    int  last_wr = 0;
    int  start_cyc;
    int  exp_lat;
    bit  fin = 1'b0;
    bit  exp_err = 1'b0;
    bit  popped;
    fifo_q.delete();
    for (int i = 0; i < AF + 4; i++) begin
      logic [63:0] w;
      w = seq_data ? 64'(256 + i) : {$urandom, $urandom};
      words.push_back(w);
      fifo_q.push_back({(i == last_pos), w});
      if (i < AF && ((i == last_pos) != (i == AF - 1))) exp_err = 1'b1;
    end
    start = 1'b1;
    start_cyc = cyc;
    drive_fifo(mode, 1'b0);
    for (int k = 0; k < 600 && !fin; k++) begin
      @(negedge clk);
      check("busy", busy, cyc != start_cyc);
      popped = fifo_read;
      if (fifo_read) begin
        check("pop_when_ready", fifo_empty_n, 1);
        pops++;
        pop_cyc.push_back(cyc);
        check("pop_count_bound", pops <= AF, 1);
      end
      if (!cen_insr) begin
        check("wen_low_on_write", wen_insr, 0);
        check("write_in_range", writes < AF, 1);
        check("addr", addr_insr, writes);
        check("data", data_to_sram, words[(writes < AF) ? writes : 0]);
        exp_lat = (pop_cyc.size() != 0) ? pop_cyc.pop_front() + 2 : -1;
        check("write_latency", cyc, exp_lat);
        writes++;
        last_wr = cyc;
      end else begin
        check("wen_high_idle", wen_insr, 1);
      end
      if (done) begin
        check("num_writes", writes, AF);
        check("num_pops", pops, AF);
        check("len_err", len_err, exp_err);
        check("done_time", cyc, last_wr + 1);
        fin = 1'b1;
      end
      if (reset_after != 0 && writes == reset_after && !fin) begin
        @(posedge clk);
        #1 reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_cen", cen_insr, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_read", fifo_read, 0);
        check("rst_done", done, 0);
        fin = 1'b1;
        popped = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      drive_fifo(mode, popped);
    end
    if (!fin) check("xfer_timeout", 0, 1);
  endtask

  // ADDR_FINAL=1 instance: one pop, one write at 0, done 4 cycles after start.
  task automatic run_one();
    int s;
    int pops = 0;
    int writes = 0;
    int wr_cyc = -1;
    bit seen = 1'b0;
    fifo_empty_n1 = 1'b1;
    fifo_last1    = 1'b1;
    fifo_data1    = 64'hCAFE_0001_0000_00A5;
    start1        = 1'b1;
    s             = cyc;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fifo_read1) pops++;
      if (!cen_insr1) begin
        writes++;
        wr_cyc = cyc;
        check("one_addr", addr_insr1, 0);
        check("one_data", data_to_sram1, 64'hCAFE_0001_0000_00A5);
      end
      if (done1) begin
        seen = 1'b1;
        check("one_done_time", cyc - s, 4);
        check("one_len_err", len_err1, 0);
      end
      @(posedge clk);
      #1 start1 = 1'b0;
    end
    check("one_pops", pops, 1);
    check("one_writes", writes, 1);
    check("one_write_time", wr_cyc - s, 3);
    check("one_done_seen", seen, 1);
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    fifo_empty_n  = 1'b0;
    fifo_data     = '0;
    fifo_last     = 1'b0;
    start1        = 1'b0;
    fifo_empty_n1 = 1'b0;
    fifo_data1    = '0;
    fifo_last1    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_cen", cen_insr, 1);
    check("rst_wen", wen_insr, 1);
    check("rst_addr", addr_insr, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_xfer(0, AF - 1, 1'b1, 0, 1'b0);
    run_xfer(1, AF - 1, 1'b1, 0, 1'b0);
    run_xfer(0, 5, 1'b0, 0, 1'b0);
    run_xfer(2, AF - 1, 1'b0, 0, 1'b0);
    run_xfer(0, AF - 1, 1'b0, 7, 1'b0);
    run_xfer(2, AF - 1, 1'b0, 0, 1'b0);
    run_xfer(0, AF - 1, 1'b0, 0, 1'b1);
    run_xfer(1, AF - 1, 1'b0, 0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      run_xfer(2, ($urandom_range(3) == 0) ? int'($urandom_range(AF)) : AF - 1, 1'b0, 0, 1'b0);
    end

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_fifo_read", fifo_read, 0);
      check("idle_cen", cen_insr, 1);
    end
    @(posedge clk);
    #1;
    run_one();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
